// File: rtl/readback_pkg.sv
// Shared constants and state encodings for the UART readback transmitter.
package readback_pkg;

    localparam int unsigned DATA_W_DEF  = 256;
    localparam int unsigned NBYTES      = DATA_W_DEF / 8;
    localparam int unsigned FRAME_BITS  = 10;   // 8N1: start + 8 data + stop
    localparam int unsigned BYTE_CNT_W  = 6;

    // Block-level sequencer
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_BYTE = 2'd1,
        S_SEND      = 2'd2,
        S_FINISH    = 2'd3
    } top_state_t;

    // Per-byte serialiser
    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_START = 2'd1,
        E_DATA  = 2'd2,
        E_STOP  = 2'd3
    } eng_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A new byte may be accepted while idle or in the last
// stop-bit cycle, so consecutive frames run back-to-back.
//   i_clk, i_rstn     : clock, async active-low reset
//   i_valid, i_byte   : byte handoff (taken when idle or on o_done)
//   o_serial          : UART line, idle high
//   o_busy            : frame in progress
//   o_done            : high during the final stop-bit cycle
module uart_tx_byte
    import readback_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_serial,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    eng_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]   r_bit;
    logic [7:0]   r_shift;
    logic         w_load;

    assign w_load = i_valid & ((r_state == E_IDLE) | o_done);

    // Bit sequencer: each bit held CLKS_PER_BIT cycles by a reloading down-counter
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= E_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            o_serial <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (w_load) begin
                r_shift  <= i_byte;
                r_cnt    <= CW'(CLKS_PER_BIT - 1);
                r_bit    <= '0;
                o_serial <= 1'b0;
                o_busy   <= 1'b1;
                r_state  <= E_START;
            end else begin
                case (r_state)
                    E_IDLE: begin
                        o_serial <= 1'b1;
                        o_busy   <= 1'b0;
                    end
                    E_START: begin
                        if (r_cnt == '0) begin
                            r_cnt    <= CW'(CLKS_PER_BIT - 1);
                            o_serial <= r_shift[0];
                            r_state  <= E_DATA;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    E_DATA: begin
                        if (r_cnt == '0) begin
                            r_cnt <= CW'(CLKS_PER_BIT - 1);
                            if (r_bit == 3'd7) begin
                                o_serial <= 1'b1;
                                r_state  <= E_STOP;
                            end else begin
                                o_serial <= r_shift[1];
                                r_shift  <= r_shift >> 1;
                                r_bit    <= r_bit + 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    E_STOP: begin
                        // o_done lands on the final stop cycle so the next load can overlap it
                        if (r_cnt == CW'(1)) begin
                            o_done <= 1'b1;
                        end
                        if (r_cnt == '0) begin
                            o_busy  <= 1'b0;
                            r_state <= E_IDLE;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    default: r_state <= E_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_readback_tx.sv
// Snapshots a DATA_W-bit block and sends it byte 0 first as back-to-back 8N1 frames.
// Optional checksum frame (XOR of all data bytes) when READBACK_CHECKSUM_EN is defined.
//   i_clk, i_rstn : clock, async active-low reset
//   i_start       : snapshot i_data and begin (ignored while busy or on o_done)
//   i_data        : block to send
//   o_tx_serial   : UART line, idle high
//   o_busy        : transfer in progress
//   o_done        : one-cycle pulse after the last stop bit
//   o_byte_cnt    : index of the frame currently on the line
module uart_readback_tx
    import readback_pkg::*;
#(
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  o_tx_serial,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [BYTE_CNT_W-1:0] o_byte_cnt
);

    localparam int unsigned BLK_BYTES = DATA_W / 8;
`ifdef READBACK_CHECKSUM_EN
    localparam int unsigned NFRAMES = BLK_BYTES + 1;
`else
    localparam int unsigned NFRAMES = BLK_BYTES;
`endif

    top_state_t        r_state;
    logic [DATA_W-1:0] r_snap;      // shifts down one byte per load; byte to send is [7:0]
    logic              w_eng_busy;
    logic              w_eng_done;
    logic              w_eng_ready;
    logic              w_more;
    logic              w_eng_valid;
    logic [7:0]        w_byte;

    assign w_eng_ready = ~w_eng_busy | w_eng_done;
    assign w_more      = (o_byte_cnt != BYTE_CNT_W'(NFRAMES - 1));
    // Next byte is handed over during the last stop cycle of the previous one
    assign w_eng_valid = ((r_state == S_LOAD_BYTE) |
                          ((r_state == S_SEND) & w_eng_done & w_more)) & w_eng_ready;

`ifdef READBACK_CHECKSUM_EN
    logic [7:0]            r_csum;
    logic [BYTE_CNT_W-1:0] w_load_idx;

    assign w_load_idx = (r_state == S_SEND) ? o_byte_cnt + BYTE_CNT_W'(1) : o_byte_cnt;
    assign w_byte     = (w_load_idx == BYTE_CNT_W'(BLK_BYTES)) ? r_csum : r_snap[7:0];

    // Running XOR of data bytes as they are handed to the serialiser
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_csum <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_csum <= '0;
        end else if (w_eng_valid) begin
            r_csum <= r_csum ^ r_snap[7:0];
        end
    end
`else
    assign w_byte = r_snap[7:0];
`endif

    // Block sequencer with registered status outputs
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= S_IDLE;
            r_snap     <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_byte_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            if (w_eng_valid) begin
                r_snap <= r_snap >> 8;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_snap     <= i_data;
                        o_busy     <= 1'b1;
                        o_byte_cnt <= '0;
                        r_state    <= S_LOAD_BYTE;
                    end
                end
                S_LOAD_BYTE: r_state <= S_SEND;
                S_SEND: begin
                    if (w_eng_done) begin
                        if (w_more) begin
                            o_byte_cnt <= o_byte_cnt + BYTE_CNT_W'(1);
                        end else begin
                            o_done     <= 1'b1;
                            o_busy     <= 1'b0;
                            o_byte_cnt <= '0;
                            r_state    <= S_FINISH;
                        end
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_valid  (w_eng_valid),
        .i_byte   (w_byte),
        .o_serial (o_tx_serial),
        .o_busy   (w_eng_busy),
        .o_done   (w_eng_done)
    );

endmodule

// File: tb/tb_uart_readback_tx.sv
// Bench for uart_readback_tx with CLKS_PER_BIT=4 and a line-decoding UART monitor.
module tb_uart_readback_tx;

    localparam int unsigned DW  = 256;
    localparam int unsigned CPB = 4;
`ifdef READBACK_CHECKSUM_EN
    localparam int NF = 33;
`else
    localparam int NF = 32;
`endif
    localparam int DONE_N = 40 * NF + 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] data = '0;
    logic          tx;
    logic          busy;
    logic          done;
    logic [5:0]    byte_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int         mon_idx = 0;
    int         mon_t = 0;
    bit         mon_active = 1'b0;
    logic [7:0] mon_sh = '0;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    csum;
        int            mode;   // 0 plain, 1 bit-timing capture, 2 spurious starts
    } vec_t;

    vec_t vecs[5];
    int   exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    uart_readback_tx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_data      (data),
        .o_tx_serial (tx),
        .o_busy      (busy),
        .o_done      (done),
        .o_byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART monitor: samples each bit mid-way and checks against the scoreboard
    always @(negedge clk) begin
        if (!rstn) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_t = 0;
                mon_sh = '0;
            end
        end else begin
            mon_t++;
            if (mon_t == 2) begin
                chk("start_bit", 64'(tx), 64'd0);
                chk("byte_cnt", 64'(byte_cnt), 64'(mon_idx));
                chk("busy_in_frame", 64'(busy), 64'd1);
            end
            if (mon_t >= 6 && mon_t <= 34 && (mon_t % 4) == 2) begin
                mon_sh = {tx, mon_sh[7:1]};
            end
            if (mon_t == 38) begin
                chk("stop_bit", 64'(tx), 64'd1);
                if (exp_q.size() == 0) begin
                    chk("spurious_frame", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("rx_byte", 64'(mon_sh), 64'(exp_q.pop_front()));
                end
                mon_idx++;
            end
            if (mon_t == 39) begin
                mon_active = 1'b0;
            end
        end
    end

    task automatic push_block(input logic [DW-1:0] d, input logic [7:0] cs);
        for (int k = 0; k < 32; k++) begin
            exp_q.push_back(d[8*k +: 8]);
        end
`ifdef READBACK_CHECKSUM_EN
        exp_q.push_back(cs);
`else
        if (cs === 8'hxx) exp_q.push_back(cs);   // keeps cs referenced; never true
`endif
    endtask

    task automatic run_block(input logic [DW-1:0] d, input logic [7:0] cs, input int mode);
        int n;
        bit got;
        @(negedge clk);
        data = d;
        start = 1'b1;
        mon_idx = 0;
        push_block(d, cs);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk("busy_after_start", 64'(busy), 64'd1);
        data = ~d;                      // later input changes must not matter
        got = 1'b0;
        while (!got && n < DONE_N + 200) begin
            @(negedge clk);
            n++;
            if (mode == 1 && n >= 2 && n <= 41) chk("line_bit", 64'(tx), 64'(exp_bits[(n - 2) / 4]));
            if (mode == 1 && n == 42) chk("no_gap_start", 64'(tx), 64'd0);
            if (mode == 2 && n == 300) start = 1'b1;
            if (mode == 2 && n == 301) start = 1'b0;
            if (done) got = 1'b1;
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("done_cycle", 64'(n), 64'(DONE_N));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("cnt_at_done", 64'(byte_cnt), 64'd0);
        chk("all_frames_rx", 64'(exp_q.size()), 64'd0);
        if (mode == 2) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", 64'(done), 64'd0);
        if (mode == 2) begin
            repeat (60) @(negedge clk);
            chk("start_on_done_ignored", 64'(busy), 64'd0);
            chk("line_idle", 64'(tx), 64'd1);
        end
    endtask

    initial begin
        logic [DW-1:0] inc;
        bit found;
        bit bad;

        for (int k = 0; k < 32; k++) inc[8*k +: 8] = 8'(k);
        vecs[0] = '{inc,               8'h00, 0};
        vecs[1] = '{{DW{1'b1}},        8'h00, 2};
        vecs[2] = '{256'h0201,         8'h03, 0};
        vecs[3] = '{256'h3CA5,         8'h99, 1};
        vecs[4] = '{{8'h80, 248'h0},   8'h80, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cnt", 64'(byte_cnt), 64'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_block(vecs[v].data, vecs[v].csum, vecs[v].mode);
        end

        // Reset in the middle of byte 5
        @(negedge clk);
        data = inc;
        start = 1'b1;
        mon_idx = 0;
        push_block(inc, 8'h00);
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mon_active && mon_idx == 5 && mon_t == 10) found = 1'b1;
        end
        chk("reached_byte5", 64'(found), 64'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_tx", 64'(tx), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_cnt", 64'(byte_cnt), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done || !tx || busy) bad = 1'b1;
        end
        chk("quiet_after_reset", 64'(bad), 64'd0);
        run_block(inc, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
